// File: rtl/exception_sequencer_pkg.sv
// rtl/exception_sequencer_pkg.sv - shared types and constants for the exception sequencer
// Contents: exc_state_t FSM encoding, cause-code constants, default vector addresses.
package exception_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_LOAD    = 3'd4,
        ST_RESTORE = 3'd5,
        ST_HALT    = 3'd6
    } exc_state_t;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV    = 2'd2;

    localparam logic [7:0] DEF_VEC_OPCODE = 8'd254;
    localparam logic [7:0] DEF_VEC_OVF    = 8'd255;
    localparam logic [7:0] DEF_VEC_DIV    = 8'd253;

endpackage

// File: rtl/exception_sequencer_priority_enc.sv
// rtl/exception_sequencer_priority_enc.sv - exception flag priority encoder
// Ports:
//   exc_flags  in  3  [0] invalid opcode, [1] overflow, [2] divide by zero
//   cause_code out 2  code of the highest-priority flag set
//   vector     out 8  handler vector byte address for that flag
// Priority is opcode > overflow > divide. Outputs are don't-care when no flag is set.
module exc_priority_enc
    import exception_sequencer_pkg::*;
#(
    parameter logic [7:0] VEC_OPCODE = DEF_VEC_OPCODE,
    parameter logic [7:0] VEC_OVF    = DEF_VEC_OVF,
    parameter logic [7:0] VEC_DIV    = DEF_VEC_DIV
) (
    input  logic [2:0] exc_flags,
    output logic [1:0] cause_code,
    output logic [7:0] vector
);

    always_comb begin
        cause_code = CAUSE_DIV;
        vector     = VEC_DIV;
        if (exc_flags[0]) begin
            cause_code = CAUSE_OPCODE;
            vector     = VEC_OPCODE;
        end else if (exc_flags[1]) begin
            cause_code = CAUSE_OVF;
            vector     = VEC_OVF;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multicycle exception entry / return sequencer
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   exc_valid, exc_flags  exception request and cause flags from the control unit
//   rte_valid             return-from-exception request
//   pc_in                 current (already incremented) PC
//   mem_rdata             memory read data, only [7:0] used
//   busy                  sequencer owns the PC and memory path
//   mem_addr, mem_rd      vector fetch address and one-cycle read strobe
//   pc_wr, pc_out         PC write enable and value
//   epc, cause            Exception PC and Cause registers
//   in_handler            a handler is running
//   done                  one-cycle completion pulse
//   halted                double fault, only reset recovers
// All outputs are flops updated on state transitions, so nothing reaches
// pc_wr or mem_rd combinationally from the inputs.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [7:0] VEC_OPCODE = DEF_VEC_OPCODE,
    parameter logic [7:0] VEC_OVF    = DEF_VEC_OVF,
    parameter logic [7:0] VEC_DIV    = DEF_VEC_DIV,
    parameter int         MEM_LAT    = 1,
    parameter int         PC_OFFSET  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [2:0]  exc_flags,
    input  logic        rte_valid,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        pc_wr,
    output logic [31:0] pc_out,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        in_handler,
    output logic        done,
    output logic        halted
);

    exc_state_t state;
    logic [2:0] count;
    logic [7:0] vec_q;
    logic [1:0] cause_q;
    logic [1:0] enc_cause;
    logic [7:0] enc_vec;
    logic       exc_req;
    logic       unused_rdata;

    assign exc_req      = exc_valid && (exc_flags != 3'b000);
    assign unused_rdata = ^mem_rdata[31:8];

    exc_priority_enc #(
        .VEC_OPCODE (VEC_OPCODE),
        .VEC_OVF    (VEC_OVF),
        .VEC_DIV    (VEC_DIV)
    ) u_enc (
        .exc_flags  (exc_flags),
        .cause_code (enc_cause),
        .vector     (enc_vec)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= 3'd0;
            vec_q      <= 8'd0;
            cause_q    <= 2'd0;
            busy       <= 1'b0;
            mem_addr   <= 32'd0;
            mem_rd     <= 1'b0;
            pc_wr      <= 1'b0;
            pc_out     <= 32'd0;
            epc        <= 32'd0;
            cause      <= 32'd0;
            in_handler <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            // Strobes default low; each is raised only for the state it belongs to.
            mem_rd <= 1'b0;
            pc_wr  <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Exception is checked first so it wins over a simultaneous rte.
                    if (exc_req && in_handler) begin
                        state  <= ST_HALT;
                        busy   <= 1'b1;
                        halted <= 1'b1;
                    end else if (exc_req) begin
                        state   <= ST_SAVE;
                        busy    <= 1'b1;
                        vec_q   <= enc_vec;
                        cause_q <= enc_cause;
                    end else if (rte_valid && in_handler) begin
                        state  <= ST_RESTORE;
                        busy   <= 1'b1;
                        pc_out <= epc;
                        pc_wr  <= 1'b1;
                        done   <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    state      <= ST_READ;
                    epc        <= pc_in - 32'(PC_OFFSET);
                    cause      <= {30'd0, cause_q};
                    in_handler <= 1'b1;
                    mem_addr   <= {24'd0, vec_q};
                    mem_rd     <= 1'b1;
                end
                ST_READ: begin
                    state <= ST_WAIT;
                    count <= 3'(MEM_LAT - 1);
                end
                ST_WAIT: begin
                    // Read data is valid on the last WAIT edge; capture it as LOAD begins.
                    if (count == 3'd0) begin
                        state  <= ST_LOAD;
                        pc_out <= {24'd0, mem_rdata[7:0]};
                        pc_wr  <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_RESTORE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    in_handler <= 1'b0;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - directed self-checking bench for exception_sequencer
module tb_exception_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = 32'h0000_0100;

    logic        exc_valid_a = 1'b0, rte_valid_a = 1'b0;
    logic [2:0]  exc_flags_a = 3'b000;
    logic [31:0] mem_rdata_a, mem_addr_a, pc_out_a, epc_a, cause_a;
    logic        busy_a, mem_rd_a, pc_wr_a, in_handler_a, done_a, halted_a;

    logic        exc_valid_b = 1'b0, rte_valid_b = 1'b0;
    logic [2:0]  exc_flags_b = 3'b000;
    logic [31:0] mem_rdata_b, mem_addr_b, pc_out_b, epc_b, cause_b;
    logic        busy_b, mem_rd_b, pc_wr_b, in_handler_b, done_b, halted_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr[7:0])
            8'd253:  mem_word = 32'hAAAA_AA60;
            8'd254:  mem_word = 32'h5555_5520;
            8'd255:  mem_word = 32'h1234_5640;
            default: mem_word = 32'h0000_00EE;
        endcase
    endfunction

    assign mem_rdata_a = mem_word(mem_addr_a);
    assign mem_rdata_b = mem_word(mem_addr_b);

    exception_sequencer #(.MEM_LAT(1)) u_dut (
        .clock(clock), .reset(reset), .exc_valid(exc_valid_a), .exc_flags(exc_flags_a),
        .rte_valid(rte_valid_a), .pc_in(pc_in), .mem_rdata(mem_rdata_a), .busy(busy_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .pc_wr(pc_wr_a), .pc_out(pc_out_a),
        .epc(epc_a), .cause(cause_a), .in_handler(in_handler_a), .done(done_a), .halted(halted_a)
    );

    exception_sequencer #(.MEM_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset), .exc_valid(exc_valid_b), .exc_flags(exc_flags_b),
        .rte_valid(rte_valid_b), .pc_in(pc_in), .mem_rdata(mem_rdata_b), .busy(busy_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .pc_wr(pc_wr_b), .pc_out(pc_out_b),
        .epc(epc_b), .cause(cause_b), .in_handler(in_handler_b), .done(done_b), .halted(halted_b)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_epc", epc_a, 32'd0);
        chk("rst_flags", {27'd0, pc_wr_a, mem_rd_a, done_a, halted_a, in_handler_a}, 32'd0);
        reset = 1'b1;
        tick();

        // Overflow exception, MEM_LAT=1: edge N samples request
        exc_valid_a = 1'b1; exc_flags_a = 3'b010; pc_in = 32'h100;
        tick();                                   // edge N -> SAVE
        exc_valid_a = 1'b0; exc_flags_a = 3'b000;
        chk("ovf_save_busy", 32'(busy_a), 32'd1);
        chk("ovf_save_rd", 32'(mem_rd_a), 32'd0);
        tick();                                   // N+1 -> READ
        chk("ovf_read_rd", 32'(mem_rd_a), 32'd1);
        chk("ovf_read_addr", mem_addr_a, 32'd255);
        chk("ovf_epc", epc_a, 32'h0000_00FC);
        chk("ovf_cause", cause_a, 32'd1);
        chk("ovf_in_handler", 32'(in_handler_a), 32'd1);
        tick();                                   // N+2 -> WAIT
        chk("ovf_wait_rd", 32'(mem_rd_a), 32'd0);
        chk("ovf_wait_addr", mem_addr_a, 32'd255);
        chk("ovf_wait_pcwr", 32'(pc_wr_a), 32'd0);
        tick();                                   // N+3 -> LOAD
        chk("ovf_load_pcwr", 32'(pc_wr_a), 32'd1);
        chk("ovf_load_pcout", pc_out_a, 32'h0000_0040);
        chk("ovf_load_done", 32'(done_a), 32'd1);
        tick();                                   // N+4 -> IDLE
        chk("ovf_idle_strobes", {29'd0, pc_wr_a, done_a, busy_a}, 32'd0);

        // Return from exception
        rte_valid_a = 1'b1;
        tick();
        rte_valid_a = 1'b0;
        chk("rte_pcwr", 32'(pc_wr_a), 32'd1);
        chk("rte_pcout", pc_out_a, 32'h0000_00FC);
        chk("rte_done", 32'(done_a), 32'd1);
        tick();
        chk("rte_in_handler", 32'(in_handler_a), 32'd0);
        chk("rte_after_pcwr", 32'(pc_wr_a), 32'd0);

        // rte without handler, exc with no flags: ignored
        rte_valid_a = 1'b1;
        tick();
        rte_valid_a = 1'b0;
        chk("rte_ignored", {30'd0, busy_a, pc_wr_a}, 32'd0);
        exc_valid_a = 1'b1; exc_flags_a = 3'b000;
        tick();
        exc_valid_a = 1'b0;
        chk("noflag_ignored", {30'd0, busy_a, in_handler_a}, 32'd0);

        // All flags plus rte at once: opcode exception wins, rte dropped
        exc_valid_a = 1'b1; exc_flags_a = 3'b111; rte_valid_a = 1'b1;
        tick();
        exc_valid_a = 1'b0; exc_flags_a = 3'b000; rte_valid_a = 1'b0;
        chk("all_save_busy", 32'(busy_a), 32'd1);
        chk("all_save_pcwr", 32'(pc_wr_a), 32'd0);
        tick();
        chk("all_read_addr", mem_addr_a, 32'd254);
        chk("all_cause", cause_a, 32'd0);
        tick();
        tick();
        chk("all_load_pcout", pc_out_a, 32'h0000_0020);
        chk("all_load_pcwr", 32'(pc_wr_a), 32'd1);
        tick();
        chk("all_in_handler", 32'(in_handler_a), 32'd1);

        // Double fault -> HALT
        exc_valid_a = 1'b1; exc_flags_a = 3'b001;
        tick();
        exc_valid_a = 1'b0; exc_flags_a = 3'b000;
        chk("df_halted", 32'(halted_a), 32'd1);
        chk("df_busy", 32'(busy_a), 32'd1);
        rte_valid_a = 1'b1;
        tick(); tick(); tick();
        rte_valid_a = 1'b0;
        chk("df_stuck", {30'd0, halted_a, pc_wr_a}, 32'd2);

        // Divide exception on MEM_LAT=3 instance: pc_wr in cycle N+6
        exc_valid_b = 1'b1; exc_flags_b = 3'b100; pc_in = 32'h200;
        tick();                                   // edge N
        exc_valid_b = 1'b0; exc_flags_b = 3'b000;
        tick();                                   // N+1 READ
        chk("div_read_addr", mem_addr_b, 32'd253);
        chk("div_read_rd", 32'(mem_rd_b), 32'd1);
        chk("div_cause", cause_b, 32'd2);
        chk("div_epc", epc_b, 32'h0000_01FC);
        tick(); tick(); tick();                   // N+4 still WAIT
        chk("div_wait_pcwr", 32'(pc_wr_b), 32'd0);
        chk("div_wait_addr", mem_addr_b, 32'd253);
        tick();                                   // N+5 LOAD
        chk("div_load_pcwr", 32'(pc_wr_b), 32'd1);
        chk("div_load_pcout", pc_out_b, 32'h0000_0060);
        tick();
        rte_valid_b = 1'b1;
        tick();
        rte_valid_b = 1'b0;
        tick();
        chk("div_rte_done", 32'(in_handler_b), 32'd0);

        // pc_in=0 wraps EPC, then reset mid-WAIT
        exc_valid_b = 1'b1; exc_flags_b = 3'b010; pc_in = 32'h0;
        tick();
        exc_valid_b = 1'b0; exc_flags_b = 3'b000;
        tick();
        chk("wrap_epc", epc_b, 32'hFFFF_FFFC);
        tick();                                   // in WAIT
        #2 reset = 1'b0;
        #1;
        chk("midrst_outs", {25'd0, busy_b, mem_rd_b, pc_wr_b, done_b, halted_b, in_handler_b, busy_a}, 32'd0);
        chk("midrst_regs", epc_b | cause_b | pc_out_b | mem_addr_b, 32'd0);
        chk("midrst_halt_a", 32'(halted_a), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("postrst_pcwr", {30'd0, pc_wr_b, busy_b}, 32'd0);
        tick(); tick(); tick();
        chk("postrst_idle", {30'd0, pc_wr_b, busy_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Multicycle sequencer that takes control of the PC and memory-address path when the main control unit flags an exception, or a return-from-exception (rte).
- On an exception it saves EPC and Cause, fetches the handler address byte from a fixed memory vector, and loads that address into the PC.
- On rte it restores the PC from EPC.
- Sits beside the main control unit. It owns the PC source and the memory address/read controls while busy is high.

Parameters:
- VEC_OPCODE, 254: byte address holding the invalid-opcode handler address.
- VEC_OVF, 255: byte address holding the overflow handler address.
- VEC_DIV, 253: byte address holding the divide-by-zero handler address.
- MEM_LAT, 1: memory read latency in cycles (range 1..7).
- PC_OFFSET, 4: value subtracted from pc_in to form EPC.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- exc_valid  in  1  exception request strobe from the control unit
- exc_flags  in  3  [0] invalid opcode, [1] ALU overflow, [2] divide by zero
- rte_valid  in  1  return-from-exception request
- pc_in  in  32  current PC (already incremented)
- mem_rdata  in  32  memory read data; only [7:0] is used
- busy  out  1  sequencer owns the PC and memory path
- mem_addr  out  32  memory address while busy
- mem_rd  out  1  one-cycle read strobe
- pc_wr  out  1  PC write enable
- pc_out  out  32  value written to the PC
- epc  out  32  Exception PC register
- cause  out  32  Cause register
- in_handler  out  1  an exception handler is running
- done  out  1  one-cycle completion pulse
- halted  out  1  double fault; core stopped

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - epc, cause, pc_out, mem_addr, count = 0.
  - All flags and strobes = 0.
  - Reset asserted mid-sequence aborts immediately; no partial PC write.
- States: IDLE, SAVE, READ, WAIT, LOAD, RESTORE, HALT.
- busy = (state != IDLE), except that busy stays high in HALT.
- IDLE:
  - exc_valid=1 with exc_flags != 0: go to SAVE.
  - exc_valid=1 with exc_flags == 0: ignored.
  - rte_valid=1 with in_handler=1: go to RESTORE.
  - rte_valid=1 with in_handler=0: ignored.
  - exc_valid and rte_valid both high: the exception wins.
  - exc_valid while in_handler=1 (double fault): go to HALT.
- Flag priority when several are set: opcode > overflow > divide.
  - Cause codes: opcode=0, overflow=1, divide=2.
  - Selected vector: VEC_OPCODE / VEC_OVF / VEC_DIV respectively.
  - The vector is latched on the IDLE->SAVE edge.
- SAVE (1 cycle):
  - epc <= pc_in - PC_OFFSET, mod 2^32 (pc_in=0 gives epc=0xFFFFFFFC).
  - cause <= zero-extended cause code.
  - in_handler <= 1.
  - Next state: READ.
- READ (1 cycle): mem_addr = vector, mem_rd = 1. Next state: WAIT with count = MEM_LAT-1.
- WAIT:
  - mem_addr is held at the vector; mem_rd = 0.
  - count decrements each cycle; go to LOAD when count reaches 0.
  - With MEM_LAT=1, WAIT lasts one cycle.
- LOAD (1 cycle):
  - pc_out = {24'b0, mem_rdata[7:0]}, pc_wr = 1, done = 1.
  - Next state: IDLE.
- Exception latency: exc_valid sampled at edge N; pc_wr is high during cycle N+3+MEM_LAT.
- RESTORE (1 cycle):
  - pc_out = epc, pc_wr = 1, done = 1.
  - in_handler <= 0.
  - Next state: IDLE.
- HALT:
  - halted = 1, busy = 1, pc_wr = 0.
  - Only reset exits HALT.
- While busy: exc_valid and rte_valid are ignored, not queued.
- Outside READ/WAIT, mem_addr holds its last value and is don't-care to consumers.
- pc_out is meaningful only while pc_wr=1.
- All outputs are registered or decoded from state. No combinational path from inputs to pc_wr or mem_rd.

Decomposition:
- Shared package holds:
  - state enum exc_state_t.
  - cause-code constants CAUSE_OPCODE, CAUSE_OVF, CAUSE_DIV.
  - default vector addresses.
- The priority encoder (exc_flags to cause code and vector) is a natural sub-module, exc_priority_enc. It is purely combinational and instantiated once.

Test Plan:
- Reset low mid-WAIT -> all outputs 0, state IDLE next cycle, no pc_wr pulse.
- pc_in=0x100, exc_flags=3'b010, mem[255]=0x40, MEM_LAT=1:
  - epc=0xFC, cause=1.
  - mem_rd high exactly one cycle with mem_addr=255.
  - pc_wr with pc_out=0x40 at N+4; done for one cycle.
- exc_flags=3'b111 -> cause=0, mem_addr=254.
- exc_flags=3'b100 with MEM_LAT=3 -> mem_addr=253; pc_wr at N+6.
- After the handler, rte_valid=1 -> pc_out=0xFC, pc_wr=1, in_handler falls. rte_valid with in_handler=0 -> no response.
- Second exc_valid while in_handler=1 -> halted=1, busy=1, no further pc_wr until reset. exc_valid=1 with flags=0 in IDLE -> ignored.
- exc_valid and rte_valid asserted together in IDLE -> exception sequence runs and the RTE is dropped.
